// File: rtl/spi_nch_frame.sv
// SPI slave frame receiver: 16-bit header, then NCH channel words and a reference word, each DW bits.
// Returns tx_data on miso during the payload. All logic runs in the clk domain.
module spi_nch_frame #(
  parameter int          NCH  = 4,
  parameter int          DW   = 14,
  parameter logic [15:0] HEAD = 16'hA5A5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DW-1:0]     tx_data,
  output logic [NCH*DW-1:0] ch_data,
  output logic [DW-1:0]     reff,
  output logic              head_flag,
  output logic              frame_valid,
  output logic              frame_err
);

  localparam int TOT  = (NCH + 1) * DW;
  localparam int CMAX = (TOT > 16) ? TOT : 16;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, HDR, PAY, DONE, DISCARD} state_t;

  state_t state_q, state_d;

  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;

  logic [CW-1:0]  cnt;
  logic [14:0]    hdr_sr;
  logic [TOT-2:0] stage;
  logic [DW-1:0]  tx_sr;

  logic           sck_rise, sck_fall, cs_fall;
  logic [15:0]    hdr_next;
  logic [TOT-1:0] stage_next;
  logic           hdr_match, hdr_miss, last_bit, short_frame;

  assign sck_rise   = sck_s2 & ~sck_d;
  assign sck_fall   = ~sck_s2 & sck_d;
  assign cs_fall    = cs_d & ~cs_s2;
  assign hdr_next   = {hdr_sr, mosi_s2};
  assign stage_next = {stage, mosi_s2};

  always_comb begin
    state_d     = state_q;
    hdr_match   = 1'b0;
    hdr_miss    = 1'b0;
    last_bit    = 1'b0;
    short_frame = 1'b0;
    if (cs_s2) begin
      state_d     = IDLE;
      short_frame = (state_q == PAY);
    end else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = HDR;
        HDR: begin
          if (sck_rise && cnt == CW'(15)) begin
            if (hdr_next == HEAD) begin
              hdr_match = 1'b1;
              state_d   = PAY;
            end else begin
              hdr_miss = 1'b1;
              state_d  = DISCARD;
            end
          end
        end
        PAY: begin
          if (sck_rise && cnt == CW'(TOT - 1)) begin
            last_bit = 1'b1;
            state_d  = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sck_s1      <= 1'b0;
      sck_s2      <= 1'b0;
      sck_d       <= 1'b0;
      cs_s1       <= 1'b0;
      cs_s2       <= 1'b0;
      cs_d        <= 1'b0;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      cnt         <= '0;
      hdr_sr      <= '0;
      stage       <= '0;
      tx_sr       <= '0;
      ch_data     <= '0;
      reff        <= '0;
      miso        <= 1'b0;
      head_flag   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sck_s1      <= sck;
      sck_s2      <= sck_s1;
      sck_d       <= sck_s2;
      cs_s1       <= cs;
      cs_s2       <= cs_s1;
      cs_d        <= cs_s2;
      mosi_s1     <= mosi;
      mosi_s2     <= mosi_s1;
      state_q     <= state_d;
      frame_valid <= last_bit;
      frame_err   <= hdr_miss | short_frame;

      if (cs_s2) begin
        cnt       <= '0;
        head_flag <= 1'b0;
        stage     <= '0;
        miso      <= 1'b0;
      end else begin
        if (state_q == IDLE && cs_fall) begin
          cnt    <= '0;
          hdr_sr <= '0;
        end
        if (state_q == HDR && sck_rise) begin
          hdr_sr <= hdr_next[14:0];
          cnt    <= hdr_match ? '0 : cnt + CW'(1);
        end
        if (hdr_match) begin
          head_flag <= 1'b1;
          tx_sr     <= tx_data;
          miso      <= tx_data[DW-1];
        end
        if (state_q == PAY) begin
          if (sck_rise) begin
            stage <= stage_next[TOT-2:0];
            if (!last_bit) cnt <= cnt + CW'(1);
          end
          // The falling edge that closes the header's last bit must not consume the MSB;
          // zero fill makes miso drop to 0 once all DW bits are out.
          if (sck_fall && cnt != '0) begin
            tx_sr <= {tx_sr[DW-2:0], 1'b0};
            miso  <= tx_sr[DW-2];
          end
          if (last_bit) begin
            for (int unsigned i = 0; i < NCH; i++)
              ch_data[i*DW +: DW] <= stage_next[TOT-1-i*DW -: DW];
            reff <= stage_next[DW-1:0];
            miso <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_nch_frame.sv
// Directed + randomized frame bench for spi_nch_frame with a word-level reference model.
module tb_spi_nch_frame;
  localparam int NCH  = 4;
  localparam int DW   = 14;
  localparam int TOT  = (NCH + 1) * DW;
  localparam int HALF = 40;

  logic              clk = 1'b0;
  logic              rstn, sck, cs, mosi;
  logic              miso;
  logic [DW-1:0]     tx_data;
  logic [NCH*DW-1:0] ch_data;
  logic [DW-1:0]     reff;
  logic              head_flag, frame_valid, frame_err;

  spi_nch_frame #(.NCH(NCH), .DW(DW), .HEAD(16'hA5A5)) dut (
    .clk(clk), .rstn(rstn), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .ch_data(ch_data), .reff(reff), .head_flag(head_flag),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  logic hf_seen = 1'b0;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err) fe_cnt++;
    if (head_flag) hf_seen = 1'b1;
  end

  // reference model state: words[0..NCH-1] are channels, words[NCH] is reff
  logic [DW-1:0]     words [NCH+1];
  logic [NCH*DW-1:0] exp_ch;
  logic [DW-1:0]     exp_reff;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TOT-1:0] stream();
    logic [TOT-1:0] s;
    s = '0;
    for (int i = 0; i <= NCH; i++) s = (s << DW) | TOT'(words[i]);
    return s;
  endfunction

  task automatic commit_model();
    for (int i = 0; i < NCH; i++) exp_ch[i*DW +: DW] = words[i];
    exp_reff = words[NCH];
  endtask

  task automatic rand_words();
    for (int i = 0; i <= NCH; i++) words[i] = DW'($urandom);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #HALF;
    m = miso;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] hdr, input logic [DW-1:0] txd);
    logic m;
    tx_data = txd;
    hf_seen = 1'b0;
    cs = 1'b0;
    #(2*HALF);
    for (int i = 15; i >= 0; i--) spi_bit(hdr[i], m);
  endtask

  task automatic pay_bits(input logic [TOT-1:0] pay, input int n, output logic [TOT-1:0] mcap);
    logic m;
    mcap = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(pay[TOT-1-i], m);
      mcap[TOT-1-i] = m;
    end
  endtask

  task automatic end_frame();
    #HALF;
    cs = 1'b1;
    #(4*HALF);
  endtask

  int fv0, fe0;
  logic [TOT-1:0] mcap;
  logic [TOT-1:0] exp_m;
  logic [DW-1:0]  txd;
  logic           m;

  initial begin
    rstn = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tx_data = '0;
    exp_ch = '0; exp_reff = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ch", 128'(ch_data), 128'(0));
    chk("rst_reff", 128'(reff), 128'(0));
    chk("rst_miso", 128'(miso), 128'(0));
    chk("rst_head", 128'(head_flag), 128'(0));
    chk("rst_fv", 128'(frame_valid), 128'(0));
    chk("rst_fe", 128'(frame_err), 128'(0));
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // known-vector frame with tx pattern, followed by extra sck cycles
    words[0] = 14'h0001; words[1] = 14'h1FFF; words[2] = 14'h2AAA; words[3] = 14'h1555; words[4] = 14'h3FFF;
    fv0 = fv_cnt; fe0 = fe_cnt;
    start_frame(16'hA5A5, 14'h2D5A);
    pay_bits(stream(), TOT, mcap);
    commit_model();
    exp_m = {14'h2D5A, {(TOT-DW){1'b0}}};
    chk("vec_miso", 128'(mcap), 128'(exp_m));
    chk("vec_head", 128'(hf_seen), 128'(1));
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom), m);
    chk("extra_miso", 128'(miso), 128'(0));
    end_frame();
    chk("vec_ch", 128'(ch_data), 128'(exp_ch));
    chk("vec_reff", 128'(reff), 128'(exp_reff));
    chk("vec_fv", 128'(fv_cnt - fv0), 128'(1));
    chk("vec_fe", 128'(fe_cnt - fe0), 128'(0));
    chk("vec_head_clr", 128'(head_flag), 128'(0));

    // bad header: payload ignored
    rand_words();
    fv0 = fv_cnt; fe0 = fe_cnt;
    start_frame(16'hA5A4, DW'($urandom));
    pay_bits(stream(), TOT, mcap);
    chk("badhdr_miso", 128'(mcap), 128'(0));
    end_frame();
    chk("badhdr_fe", 128'(fe_cnt - fe0), 128'(1));
    chk("badhdr_fv", 128'(fv_cnt - fv0), 128'(0));
    chk("badhdr_head", 128'(hf_seen), 128'(0));
    chk("badhdr_ch", 128'(ch_data), 128'(exp_ch));
    chk("badhdr_reff", 128'(reff), 128'(exp_reff));

    // short frame: cs rises after 40 payload bits
    rand_words();
    fv0 = fv_cnt; fe0 = fe_cnt;
    start_frame(16'hA5A5, DW'($urandom));
    pay_bits(stream(), 40, mcap);
    chk("short_head_hi", 128'(head_flag), 128'(1));
    #HALF;
    @(negedge clk);
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("short_head_fall", 128'(head_flag), 128'(0));
    #(4*HALF);
    chk("short_fe", 128'(fe_cnt - fe0), 128'(1));
    chk("short_fv", 128'(fv_cnt - fv0), 128'(0));
    chk("short_ch", 128'(ch_data), 128'(exp_ch));
    chk("short_reff", 128'(reff), 128'(exp_reff));

    // reset at payload bit 30, then a full valid frame
    rand_words();
    fv0 = fv_cnt; fe0 = fe_cnt;
    start_frame(16'hA5A5, DW'($urandom));
    pay_bits(stream(), 30, mcap);
    @(negedge clk);
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_ch = '0; exp_reff = '0;
    chk("abort_head", 128'(head_flag), 128'(0));
    chk("abort_ch", 128'(ch_data), 128'(exp_ch));
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) spi_bit(1'($urandom), m);
    end_frame();
    chk("abort_fv", 128'(fv_cnt - fv0), 128'(0));
    chk("abort_fe", 128'(fe_cnt - fe0), 128'(0));
    chk("abort_reff", 128'(reff), 128'(exp_reff));

    // randomized full frames, the first one being the post-reset recovery frame
    for (int f = 0; f < 5; f++) begin
      rand_words();
      txd = DW'($urandom);
      fv0 = fv_cnt; fe0 = fe_cnt;
      start_frame(16'hA5A5, txd);
      pay_bits(stream(), TOT, mcap);
      commit_model();
      exp_m = {txd, {(TOT-DW){1'b0}}};
      chk("rnd_miso", 128'(mcap), 128'(exp_m));
      end_frame();
      chk("rnd_ch", 128'(ch_data), 128'(exp_ch));
      chk("rnd_reff", 128'(reff), 128'(exp_reff));
      chk("rnd_fv", 128'(fv_cnt - fv0), 128'(1));
      chk("rnd_fe", 128'(fe_cnt - fe0), 128'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_nch_frame.md
SPI_NCH_FRAME -- requirements
Module: spi_nch_frame

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of payload channel words per frame (1..16).
REQ-002 SHALL have parameter DW, default 14, the bit width of each channel word and of the reference word (4..32).
REQ-003 SHALL have parameter HEAD, default 16'hA5A5, the 16-bit frame header value.
REQ-004 SHALL have port clk  input  1  system clock, the single clock; every register in the block SHALL be clocked on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sck  input  1  SPI clock, asynchronous to clk, mode 0.
REQ-007 SHALL have port cs  input  1  SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port mosi  input  1  SPI serial data in.
REQ-009 SHALL have port miso  output  1  SPI serial data out.
REQ-010 SHALL have port tx_data  input  DW  result word returned on miso.
REQ-011 SHALL have port ch_data  output  NCH*DW  received channel words, channel 0 in bits [DW-1:0].
REQ-012 SHALL have port reff  output  DW  received reference word.
REQ-013 SHALL have port head_flag  output  1  level, high from header match until cs deasserts.
REQ-014 SHALL have port frame_valid  output  1  one-clk pulse when a complete frame has been committed.
REQ-015 SHALL have port frame_err  output  1  one-clk pulse on a header mismatch or a short frame.

Function
REQ-016 SHALL pass sck, cs and mosi through 2-flop synchronisers; sck edges SHALL be detected in the clk domain with a 1-cycle edge register; sck SHALL be assumed ≤ clk/4.
REQ-017 SHALL implement the FSM states IDLE, HDR, PAY, DONE and DISCARD.
REQ-018 SHALL force the FSM to IDLE from any state whenever synchronised cs is high, and SHALL clear the bit counter and head_flag at the same time.
REQ-019 SHALL move from IDLE to HDR on the synchronised cs falling edge.
REQ-020 SHALL sample mosi MSB-first on each synchronised sck rising edge while in HDR or PAY.
REQ-021 SHALL, in HDR, compare the 16-bit shift register with HEAD after the 16th rising edge: on a match, enter PAY and set head_flag the next clk; on a mismatch, enter DISCARD and pulse frame_err.
REQ-022 SHALL, in PAY, shift (NCH+1)*DW bits in order ch0..ch(NCH-1) then reff, into a staging register only.
REQ-023 SHALL, on the last PAY bit, update ch_data and reff atomically from staging in the same cycle, pulse frame_valid the following clk, and enter DONE.
REQ-024 SHALL ignore all further sck edges in DONE and DISCARD until cs rises.
REQ-025 SHALL treat cs rising while in PAY as a short frame: pulse frame_err, discard staging, and leave ch_data and reff unchanged.
REQ-026 SHALL, on header match, latch tx_data into the tx shift register and drive its MSB on miso in the same clk that head_flag rises.
REQ-027 SHALL, in PAY, advance miso by one bit on each synchronised sck falling edge.
REQ-028 SHALL drive miso 0 after the DW-th bit has been sent.
REQ-029 SHALL drive miso 0 in every state other than PAY.
REQ-030 SHALL, when a cs falling edge and a cs rising edge are seen within the synchroniser window, act only on the final synchronised level.
REQ-031 SHALL use a bit counter wide enough for (NCH+1)*DW and SHALL never let it wrap within a frame.

Reset
REQ-032 SHALL, while rstn is low at a clk rising edge, clear to 0 the FSM (to IDLE), the synchronisers, the counters, the staging register, the tx shift register, ch_data, reff, miso, head_flag, frame_valid and frame_err.
REQ-033 SHALL, on rstn low mid-frame, abandon the frame with no frame_valid pulse and no frame_err pulse.
REQ-034 SHALL, after rstn is released, accept a new frame only after a fresh cs falling edge.

Verification
REQ-035 SHALL cover: NCH=4, DW=14, header A5A5, ch0..3 = 0x0001/0x1FFF/0x2AAA/0x1555, reff = 0x3FFF -> ch_data and reff match, exactly one frame_valid pulse, frame_err stays 0.
REQ-036 SHALL cover: header 0xA5A4 -> frame_err pulses once, head_flag stays 0, outputs unchanged, payload bits ignored.
REQ-037 SHALL cover: cs rises after 40 of the 70 payload bits -> frame_err pulses, prior ch_data retained, head_flag falls within 3 clk.
REQ-038 SHALL cover: tx_data = 0x2D5A -> miso carries 10_1101_0101_1010 across the first 14 payload sck periods, then 0 until cs rises.
REQ-039 SHALL cover: rstn asserted at payload bit 30, then a full valid frame -> no frame_valid for the aborted frame, and the second frame commits correctly.
REQ-040 SHALL cover: 8 extra sck cycles after a complete frame -> outputs stable and a single frame_valid pulse.
